// File: rtl/axi_lite_io_responder_pkg.sv
// Shared constants and FSM state types for the AXI4-lite I/O responder.
// Register offsets, response codes, STAT/CTRL bit positions.
`timescale 1ns/1ps
package axi_io_pkg;

    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [3:0] ADDR_CTRL = 4'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned STAT_RX_VALID = 0;
    localparam int unsigned STAT_RX_FULL  = 1;
    localparam int unsigned STAT_TX_EMPTY = 2;
    localparam int unsigned STAT_TX_FULL  = 3;
    localparam int unsigned STAT_IRQ_EN   = 4;

    localparam int unsigned CTRL_TX_CLR = 0;
    localparam int unsigned CTRL_RX_CLR = 1;
    localparam int unsigned CTRL_IRQ_EN = 4;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

endpackage

// File: rtl/axi_lite_io_responder_sync_fifo.sv
// Synchronous FIFO with clear; head is presented combinationally (0 when empty).
// Push while full is ignored even if a pop happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rptr];

    // Pointer and occupancy update; clear overrides any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents are don't-care once pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/axi_lite_io_responder.sv
// AXI4-lite slave fronting a byte-stream serial peripheral (TX/RX FIFOs).
// Optional macro AXI_IO_IRQ_EN adds the irq output and CTRL/STAT bit4.
`timescale 1ns/1ps
module axi_lite_io_responder
    import axi_io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef AXI_IO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    wstate_t wstate, wstate_nx;
    rstate_t rstate, rstate_nx;

    logic              aw_held, w_held;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_take, w_take, wr_fire;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [3:0]        wr_strb;
    logic [1:0]        wr_resp;
    logic              tx_push, tx_clr, rx_clr, ctrl_wr;

    logic              rd_fire, rd_pop;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data_nx;
    logic [1:0]        rd_resp_nx;
    logic [7:0]        stat;

    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]        rx_head;
    logic [CW-1:0]     tx_count, rx_count;
    logic              irq_en_bit;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .clear(tx_clr),
        .push(tx_push), .pop(tx_valid & tx_ready), .din(wr_data),
        .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .clear(rx_clr),
        .push(rx_valid), .pop(rd_pop), .din(rx_data),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) wstate <= W_IDLE;
        else       wstate <= wstate_nx;
    end

    // Write FSM: per-channel readies, joint-capture detection, next state.
    always_comb begin
        wstate_nx     = wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        wr_fire       = 1'b0;
        case (wstate)
            W_IDLE: begin
                s_axi_awready = ~aw_held;
                s_axi_wready  = ~w_held;
                wr_fire = (aw_held | (s_axi_awvalid & ~aw_held)) &
                          (w_held  | (s_axi_wvalid  & ~w_held));
                if (wr_fire) wstate_nx = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
        aw_take = s_axi_awvalid & s_axi_awready;
        w_take  = s_axi_wvalid & s_axi_wready;
    end

    // Write decode: pick latched or live AW/W values, derive side effects and response.
    always_comb begin
        wr_addr = aw_held ? waddr_q : s_axi_awaddr[ADDR_W-1:0];
        wr_data = w_held  ? wdata_q : s_axi_wdata[7:0];
        wr_strb = w_held  ? wstrb_q : s_axi_wstrb;
        wr_resp = RESP_SLVERR;
        tx_push = 1'b0;
        tx_clr  = 1'b0;
        rx_clr  = 1'b0;
        ctrl_wr = 1'b0;
        if (wr_addr == ADDR_W'(ADDR_TX)) begin
            wr_resp = tx_full ? RESP_SLVERR : RESP_OKAY;
            tx_push = wr_fire & (|wr_strb) & ~tx_full;
        end else if (wr_addr == ADDR_W'(ADDR_CTRL)) begin
            wr_resp = RESP_OKAY;
            ctrl_wr = wr_fire;
            tx_clr  = wr_fire & wr_data[CTRL_TX_CLR];
            rx_clr  = wr_fire & wr_data[CTRL_RX_CLR];
        end
    end

    // Write channel capture registers and response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_axi_bresp <= RESP_OKAY;
        end else if (wr_fire) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            s_axi_bresp <= wr_resp;
        end else begin
            if (aw_take) begin
                aw_held <= 1'b1;
                waddr_q <= s_axi_awaddr[ADDR_W-1:0];
            end
            if (w_take) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi_wdata[7:0];
                wstrb_q <= s_axi_wstrb;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) rstate <= R_IDLE;
        else       rstate <= rstate_nx;
    end

    // Read FSM and read decode; STAT reflects pre-update occupancy.
    always_comb begin
        rstate_nx     = rstate;
        s_axi_arready = (rstate == R_IDLE);
        s_axi_rvalid  = (rstate == R_RESP);
        rd_fire       = s_axi_arvalid & s_axi_arready;
        rd_addr       = s_axi_araddr[ADDR_W-1:0];
        rd_pop        = 1'b0;
        rd_data_nx    = '0;
        rd_resp_nx    = RESP_SLVERR;
        stat          = '0;
        stat[STAT_RX_VALID] = ~rx_empty;
        stat[STAT_RX_FULL]  = rx_full;
        stat[STAT_TX_EMPTY] = tx_empty;
        stat[STAT_TX_FULL]  = tx_full;
        stat[STAT_IRQ_EN]   = irq_en_bit;
        if (rd_addr == ADDR_W'(ADDR_RX)) begin
            rd_resp_nx = RESP_OKAY;
            rd_data_nx = {24'b0, rx_head};
            rd_pop     = rd_fire & ~rx_empty;
        end else if (rd_addr == ADDR_W'(ADDR_STAT)) begin
            rd_resp_nx = RESP_OKAY;
            rd_data_nx = {24'b0, stat};
        end
        case (rstate)
            R_IDLE:  if (rd_fire) rstate_nx = R_RESP;
            R_RESP:  if (s_axi_rready) rstate_nx = R_IDLE;
            default: rstate_nx = R_IDLE;
        endcase
    end

    // Read response registers, loaded only on the AR handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (rd_fire) begin
            s_axi_rdata <= rd_data_nx;
            s_axi_rresp <= rd_resp_nx;
        end
    end

`ifdef AXI_IO_IRQ_EN
    logic irq_en_q, rx_ne_q, tx_e_q;

    assign irq_en_bit = irq_en_q;

    // Interrupt: one-cycle pulse on rising rx-not-empty or tx-empty while enabled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            irq_en_q <= 1'b0;
            rx_ne_q  <= 1'b0;
            tx_e_q   <= 1'b1;
            irq      <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= wr_data[CTRL_IRQ_EN];
            rx_ne_q <= ~rx_empty;
            tx_e_q  <= tx_empty;
            irq     <= irq_en_q & ((~rx_empty & ~rx_ne_q) | (tx_empty & ~tx_e_q));
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:ADDR_W],
                         s_axi_araddr[31:ADDR_W], s_axi_wdata[31:8], tx_count, rx_count, ctrl_wr};

endmodule

// File: tb/tb_axi_lite_io_responder.sv
// Scoreboard bench for axi_lite_io_responder: stimulus pushes expected B/R/TX
// results into queues; negedge monitors pop and compare on each handshake.
`timescale 1ns/1ps
module tb_axi_lite_io_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [7:0]  tx_data, rx_data = '0;
    logic        tx_valid, tx_ready = 0, rx_valid = 0, rx_ready;
`ifdef AXI_IO_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    logic [1:0]  bq[$];
    logic [31:0] rdq[$];
    logic [1:0]  rrq[$];
    logic [7:0]  txq[$];

    always #5 clk = ~clk;

    axi_lite_io_responder #(.FIFO_DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(3'b000),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef AXI_IO_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: compare every handshake against the head of its scoreboard queue.
    initial forever begin
        @(negedge clk);
        if (rstn && bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", 32'(bvalid), 32'(0));
            else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
        end
        if (rstn && rvalid && rready) begin
            if (rdq.size() == 0) chk("r_unexpected", 32'(rvalid), 32'(0));
            else begin
                chk("rdata", rdata, rdq.pop_front());
                chk("rresp", 32'(rresp), 32'(rrq.pop_front()));
            end
        end
        if (rstn && tx_valid && tx_ready) begin
            if (txq.size() == 0) chk("tx_unexpected", 32'(tx_valid), 32'(0));
            else chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
        end
    end

    // mode 0: AW and W together, 1: AW first, 2: W first. rx_pulse offers 0x88 on rx in the first cycle.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input logic [1:0] er, input logic rx_pulse);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        bq.push_back(er);
        awaddr = a; wdata = d; wstrb = s;
        if (mode != 2) awvalid = 1;
        if (mode != 1) wvalid = 1;
        if (rx_pulse) begin rx_valid = 1; rx_data = 8'h88; end
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            rx_valid = 0;
            if (aw_hs) begin awvalid = 0; aw_done = 1; end
            if (w_hs)  begin wvalid = 0;  w_done = 1; end
            if (mode == 1 && aw_done && !w_done) wvalid = 1;
            if (mode == 2 && w_done && !aw_done) awvalid = 1;
            n++;
        end
        if (n >= 20) begin
            chk("aw_w_timeout", 32'(n), 32'(0));
            awvalid = 0; wvalid = 0;
            void'(bq.pop_back());
            return;
        end
        @(negedge clk);
        chk("b_latency", 32'(bvalid), 32'(1));
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n = 0;
        rdq.push_back(ed); rrq.push_back(er);
        araddr = a; arvalid = 1;
        @(negedge clk);
        while (!arready && n < 20) begin @(posedge clk); #1; @(negedge clk); n++; end
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            chk("r_timeout", 32'(n), 32'(0));
            void'(rdq.pop_back()); void'(rrq.pop_back());
        end
        @(posedge clk); #1;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_valid = 1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        // Reset state.
        @(negedge clk);
        chk("rst_awready", 32'(awready), 32'(1));
        chk("rst_wready", 32'(wready), 32'(1));
        chk("rst_arready", 32'(arready), 32'(1));
        chk("rst_bvalid", 32'(bvalid), 32'(0));
        chk("rst_rvalid", 32'(rvalid), 32'(0));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        chk("rst_rx_ready", 32'(rx_ready), 32'(1));
        chk("rst_rdata", rdata, 32'(0));
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;

        // 1: TX push with AW leading W, then drain one byte.
        axi_write(32'h4, 32'h41, 4'hF, 1, 2'b00, 0);
        @(negedge clk);
        chk("t1_tx_valid", 32'(tx_valid), 32'(1));
        chk("t1_tx_data", 32'(tx_data), 32'h41);
        @(posedge clk); #1;
        txq.push_back(8'h41);
        tx_ready = 1;
        @(posedge clk); #1;
        tx_ready = 0;
        @(negedge clk);
        chk("t1_tx_drained", 32'(tx_valid), 32'(0));
        @(posedge clk); #1;

        // Zero strobe drops the push; bad addresses return SLVERR.
        axi_write(32'h4, 32'h99, 4'h0, 2, 2'b00, 0);
        axi_write(32'h0, 32'h12, 4'hF, 0, 2'b10, 0);
        axi_write(32'h8, 32'h12, 4'hF, 0, 2'b10, 0);
        axi_read(32'h4, 32'h0, 2'b10);
        axi_read(32'hC, 32'h0, 2'b10);
        axi_read(32'h8, 32'h4, 2'b00);

        // 2: RX bytes popped in order; empty read returns 0 OKAY.
        rx_send(8'h10);
        rx_send(8'h20);
        axi_read(32'h0, 32'h10, 2'b00);
        axi_read(32'h0, 32'h20, 2'b00);
        axi_read(32'h0, 32'h00, 2'b00);
        axi_read(32'h8, 32'h4, 2'b00);

        // 3: fill TX (depth 16), 17th push is rejected, then drain in order.
        for (int unsigned i = 0; i < 17; i++)
            axi_write(32'h4, 32'h30 + i, 4'hF, int'(i % 3), (i < 16) ? 2'b00 : 2'b10, 0);
        axi_read(32'h8, 32'h8, 2'b00);
        for (int unsigned i = 0; i < 16; i++) txq.push_back(8'(8'h30 + i));
        tx_ready = 1;
        n = 0;
        @(negedge clk);
        while (tx_valid && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        tx_ready = 0;
        chk("t3_drain_left", 32'(txq.size()), 32'(0));
        chk("t3_drain_bound", 32'(n < 40), 32'(1));

        // 4: rready held low for 5 cycles; response stable, arready low, one pop.
        rx_send(8'h55);
        rx_send(8'h66);
        rready = 0;
        rdq.push_back(32'h55); rrq.push_back(2'b00);
        araddr = 32'h0; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_rvalid", 32'(rvalid), 32'(1));
            chk("t4_rdata", rdata, 32'h55);
            chk("t4_arready", 32'(arready), 32'(0));
        end
        @(posedge clk); #1;
        rready = 1;
        @(posedge clk); #1;
        axi_read(32'h0, 32'h66, 2'b00);
        axi_read(32'h0, 32'h00, 2'b00);

        // 5: RX clear wins over a same-cycle receiver push.
        rx_send(8'h77);
        axi_write(32'hC, 32'h2, 4'hF, 0, 2'b00, 1);
        axi_read(32'h8, 32'h4, 2'b00);
        axi_read(32'h0, 32'h0, 2'b00);

        // TX clear discards queued bytes.
        axi_write(32'h4, 32'hA1, 4'hF, 0, 2'b00, 0);
        axi_write(32'h4, 32'hA2, 4'hF, 0, 2'b00, 0);
        axi_write(32'hC, 32'h1, 4'hF, 0, 2'b00, 0);
        @(negedge clk);
        chk("txclr_tx_valid", 32'(tx_valid), 32'(0));
        @(posedge clk); #1;
        axi_read(32'h8, 32'h4, 2'b00);

        // 6: interrupt enable.
        axi_write(32'hC, 32'h10, 4'hF, 0, 2'b00, 0);
`ifdef AXI_IO_IRQ_EN
        axi_read(32'h8, 32'h14, 2'b00);
        n = 0;
        rx_send(8'h01);
        for (int unsigned i = 0; i < 5; i++) begin @(negedge clk); n += int'(irq); end
        chk("t6_irq_first", 32'(n), 32'(1));
        @(posedge clk); #1;
        n = 0;
        rx_send(8'h02);
        for (int unsigned i = 0; i < 5; i++) begin @(negedge clk); n += int'(irq); end
        chk("t6_irq_second", 32'(n), 32'(0));
        @(posedge clk); #1;
`else
        axi_read(32'h8, 32'h4, 2'b00);
        rx_send(8'h01);
        rx_send(8'h02);
`endif
        axi_read(32'h0, 32'h01, 2'b00);
        axi_read(32'h0, 32'h02, 2'b00);

        repeat (4) @(posedge clk);
        chk("bq_left", 32'(bq.size()), 32'(0));
        chk("rq_left", 32'(rdq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
